// File: rtl/need_update_scheduler.sv
// Funnels button presses and per-need decay timer expiries into one valid/ready update port.
// Build option SCHED_RR_EN selects round-robin within each request class; fixed priority otherwise.
module need_update_scheduler #(
  parameter int TICK_DIV         = 5000000,
  parameter int PERIOD_SALUD     = 156,
  parameter int PERIOD_ENERGIA   = 130,
  parameter int PERIOD_HAMBRE    = 91,
  parameter int PERIOD_DIVERSION = 65
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_req,
  input  logic       awake,
  input  logic       test_mode,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [1:0] upd_idx,
  output logic       upd_op,
  output logic       upd_src,
  output logic       tick,
  output logic [7:0] pend
);

  localparam int DIV_W = 23;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0][7:0] PER_LAST = {
    8'(PERIOD_DIVERSION - 1),
    8'(PERIOD_HAMBRE - 1),
    8'(PERIOD_ENERGIA - 1),
    8'(PERIOD_SALUD - 1)
  };
  localparam logic [1:0] IDX_ENERGIA = 2'd1;

  logic [DIV_W-1:0] div_cnt;
  logic [3:0][7:0]  per_cnt;
  logic [3:0]       pend_btn;
  logic [3:0]       pend_tmr;

  logic [3:0] btn_set;
  logic [3:0] tmr_wrap;
  logic [1:0] btn_start;
  logic [1:0] tmr_start;
  logic [2:0] btn_pick;
  logic [2:0] tmr_pick;
  logic       can_grant;
  logic       grant_btn;
  logic       grant_tmr;
  logic [1:0] win_idx;
  logic       win_op;
  logic [3:0] clr_btn;
  logic [3:0] clr_tmr;

  // Returns {found, index}; search begins at start and wraps, first hit wins.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] j;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      j = start + 2'(k);
      if (req[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  assign pend = {pend_tmr, pend_btn};

  // Energía presses are meaningless while the pet sleeps.
  assign btn_set = btn_req & {1'b1, 1'b1, awake, 1'b1};

  always_comb begin
    tmr_wrap = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tmr_wrap[i] = tick && !test_mode && (per_cnt[i] == PER_LAST[i]);
    end
  end

`ifdef SCHED_RR_EN
  logic [1:0] ptr_btn;
  logic [1:0] ptr_tmr;

  assign btn_start = ptr_btn;
  assign tmr_start = ptr_tmr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_btn <= 2'd0;
      ptr_tmr <= 2'd0;
    end else begin
      if (grant_btn) ptr_btn <= btn_pick[1:0] + 2'd1;
      if (grant_tmr) ptr_tmr <= tmr_pick[1:0] + 2'd1;
    end
  end
`else
  assign btn_start = 2'd0;
  assign tmr_start = 2'd0;
`endif

  // Valid/ready: a command is transferred on an edge where upd_valid and upd_ready are both 1.
  // While valid is up and ready is low the command fields hold still; a new grant is only
  // taken when the port is empty or is being emptied at that same edge.
  always_comb begin
    btn_pick  = pick(pend_btn, btn_start);
    tmr_pick  = pick(pend_tmr, tmr_start);
    can_grant = !upd_valid || upd_ready;
    grant_btn = can_grant && btn_pick[2];
    grant_tmr = can_grant && !btn_pick[2] && tmr_pick[2];
    win_idx   = btn_pick[2] ? btn_pick[1:0] : tmr_pick[1:0];
    win_op    = btn_pick[2] ? 1'b1 : ((tmr_pick[1:0] == IDX_ENERGIA) && !awake);
    clr_btn   = grant_btn ? (4'b0001 << btn_pick[1:0]) : 4'b0000;
    clr_tmr   = grant_tmr ? (4'b0001 << tmr_pick[1:0]) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt <= '0;
    end else if (tick && !test_mode) begin
      for (int i = 0; i < 4; i++) begin
        per_cnt[i] <= tmr_wrap[i] ? 8'd0 : per_cnt[i] + 8'd1;
      end
    end
  end

  // Set wins over clear so a request colliding with its own grant is kept as a new event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_btn <= 4'b0000;
      pend_tmr <= 4'b0000;
    end else begin
      pend_btn <= (pend_btn & ~clr_btn) | btn_set;
      pend_tmr <= test_mode ? 4'b0000 : ((pend_tmr & ~clr_tmr) | tmr_wrap);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_valid <= 1'b0;
      upd_idx   <= 2'd0;
      upd_op    <= 1'b0;
      upd_src   <= 1'b0;
    end else if (can_grant) begin
      upd_valid <= btn_pick[2] || tmr_pick[2];
      if (btn_pick[2] || tmr_pick[2]) begin
        upd_idx <= win_idx;
        upd_op  <= win_op;
        upd_src <= btn_pick[2];
      end
    end
  end

endmodule

// File: tb/tb_need_update_scheduler.sv
// Directed bench for need_update_scheduler with a short divider and small decay periods.
module tb_need_update_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_req;
  logic       awake;
  logic       test_mode;
  logic       upd_valid;
  logic       upd_ready;
  logic [1:0] upd_idx;
  logic       upd_op;
  logic       upd_src;
  logic       tick;
  logic [7:0] pend;

  int total = 0;
  int bad   = 0;

  need_update_scheduler #(
    .TICK_DIV(4),
    .PERIOD_SALUD(200),
    .PERIOD_ENERGIA(5),
    .PERIOD_HAMBRE(4),
    .PERIOD_DIVERSION(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_req(btn_req),
    .awake(awake),
    .test_mode(test_mode),
    .upd_valid(upd_valid),
    .upd_ready(upd_ready),
    .upd_idx(upd_idx),
    .upd_op(upd_op),
    .upd_src(upd_src),
    .tick(tick),
    .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cmd(input string tag, input logic v, input logic [1:0] idx,
                         input logic op, input logic src);
    chk({tag, "_valid"}, 8'(upd_valid), 8'(v));
    chk({tag, "_idx"}, 8'(upd_idx), 8'(idx));
    chk({tag, "_op"}, 8'(upd_op), 8'(op));
    chk({tag, "_src"}, 8'(upd_src), 8'(src));
  endtask

  initial begin
    logic [1:0] exp_second;
    logic [1:0] exp_third;
    logic [7:0] exp_pend_second;
`ifdef SCHED_RR_EN
    exp_second      = 2'd2;
    exp_third       = 2'd0;
    exp_pend_second = 8'h01;
`else
    exp_second      = 2'd0;
    exp_third       = 2'd2;
    exp_pend_second = 8'h04;
`endif

    // Reset with every button held
    rst_n = 1'b0; btn_req = 4'hF; test_mode = 1'b1; awake = 1'b1; upd_ready = 1'b1;
    step(); step();
    chk_cmd("rst", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rst_tick", 8'(tick), 8'h00);
    chk("rst_pend", pend, 8'h00);
    rst_n = 1'b1; btn_req = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 8'(upd_valid), 8'h00);
      chk("post_rst_pend", pend, 8'h00);
    end

    // Simultaneous buttons, bit 0 re-pressed while it is being granted
    btn_req = 4'b0101;
    step();
    chk("sim_pend0", pend, 8'h05);
    chk("sim_valid0", 8'(upd_valid), 8'h00);
    step();
    btn_req = 4'b0000;
    chk_cmd("sim_first", 1'b1, 2'd0, 1'b1, 1'b1);
    chk("sim_pend1", pend, 8'h05);
    step();
    chk_cmd("sim_second", 1'b1, exp_second, 1'b1, 1'b1);
    chk("sim_pend2", pend, exp_pend_second);
    step();
    chk_cmd("sim_third", 1'b1, exp_third, 1'b1, 1'b1);
    chk("sim_pend3", pend, 8'h00);
    step();
    chk("sim_idle", 8'(upd_valid), 8'h00);

    // Stall with a re-press of salud
    upd_ready = 1'b0; btn_req = 4'b0001;
    step();
    btn_req = 4'b0000;
    chk("stall_pend_a", pend, 8'h01);
    chk("stall_valid_a", 8'(upd_valid), 8'h00);
    step();
    chk_cmd("stall_c2", 1'b1, 2'd0, 1'b1, 1'b1);
    chk("stall_pend_c2", pend, 8'h00);
    btn_req = 4'b0001;
    step();
    btn_req = 4'b0000;
    chk_cmd("stall_c3", 1'b1, 2'd0, 1'b1, 1'b1);
    chk("stall_pend_c3", pend, 8'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_cmd("stall_hold", 1'b1, 2'd0, 1'b1, 1'b1);
      chk("stall_pend_hold", pend, 8'h01);
    end
    upd_ready = 1'b1;
    step();
    chk_cmd("stall_reissue", 1'b1, 2'd0, 1'b1, 1'b1);
    chk("stall_pend_done", pend, 8'h00);
    step();
    chk("stall_idle", 8'(upd_valid), 8'h00);

    // Fresh reset, decay running
    rst_n = 1'b0; test_mode = 1'b0; awake = 1'b1; upd_ready = 1'b1; btn_req = 4'h0;
    step(); step();
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("decay_tick", 8'(tick), 8'((c % 4) == 0));
      chk("decay_valid", 8'(upd_valid), 8'h00);
      chk("decay_pend", pend, 8'h00);
    end
    step();  // cycle 13
    chk("div_pend", pend, 8'h80);
    chk("div_tick13", 8'(tick), 8'h00);
    step();  // 14
    chk_cmd("div_cmd", 1'b1, 2'd3, 1'b0, 1'b0);
    chk("div_pend_clr", pend, 8'h00);
    step();  // 15
    chk("div_idle", 8'(upd_valid), 8'h00);
    chk("tick15", 8'(tick), 8'h00);
    step();  // 16
    chk("tick16", 8'(tick), 8'h01);

    // Class priority: diversión button against hambre timer
    btn_req = 4'b1000;
    step();  // 17
    btn_req = 4'b0000;
    chk("cls_pend", pend, 8'h48);
    chk("tick17", 8'(tick), 8'h00);
    step();  // 18
    chk_cmd("cls_btn", 1'b1, 2'd3, 1'b1, 1'b1);
    chk("cls_pend18", pend, 8'h40);
    step();  // 19
    chk_cmd("cls_tmr", 1'b1, 2'd2, 1'b0, 1'b0);
    chk("cls_pend19", pend, 8'h00);

    // Asleep: energía timer is a recovery, energía button ignored
    awake = 1'b0;
    step();  // 20
    chk("sleep_idle", 8'(upd_valid), 8'h00);
    chk("tick20", 8'(tick), 8'h01);
    btn_req = 4'b0010;
    step();  // 21
    btn_req = 4'b0000;
    chk("sleep_pend", pend, 8'h20);
    step();  // 22
    chk_cmd("sleep_cmd", 1'b1, 2'd1, 1'b1, 1'b0);
    chk("sleep_pend22", pend, 8'h00);

    // Stall across a diversión wrap; waking must not alter the held opcode
    upd_ready = 1'b0; awake = 1'b1;
    step();  // 23
    chk_cmd("hold23", 1'b1, 2'd1, 1'b1, 1'b0);
    step();  // 24
    chk("tick24", 8'(tick), 8'h01);
    step();  // 25
    chk("wrap_in_stall", pend, 8'h80);
    chk_cmd("hold25", 1'b1, 2'd1, 1'b1, 1'b0);
    step();  // 26
    chk("wrap_waits", pend, 8'h80);
    test_mode = 1'b1;
    step();  // 27
    chk("tm_clear", pend, 8'h00);
    chk_cmd("hold27", 1'b1, 2'd1, 1'b1, 1'b0);
    upd_ready = 1'b1;
    step();  // 28
    chk("tm_idle", 8'(upd_valid), 8'h00);
    btn_req = 4'b0100;
    step();  // 29
    btn_req = 4'b0000;
    chk("tm_btn_pend", pend, 8'h04);
    step();  // 30
    chk_cmd("tm_btn_cmd", 1'b1, 2'd2, 1'b1, 1'b1);
    for (int c = 31; c <= 41; c++) begin
      step();
      chk("tm_frozen_pend", pend, 8'h00);
      chk("tm_frozen_valid", 8'(upd_valid), 8'h00);
    end
    test_mode = 1'b0;

    // Counters resume from frozen values: hambre at 2, diversión at 0
    for (int c = 42; c <= 48; c++) begin
      step();
      chk("resume_pend", pend, 8'h00);
    end
    step();  // 49
    chk("resume_ham", pend, 8'h40);
    step();  // 50
    chk_cmd("resume_cmd", 1'b1, 2'd2, 1'b0, 1'b0);
    step();  // 51
    chk("resume_idle", 8'(upd_valid), 8'h00);
    step();  // 52
    chk("tick52", 8'(tick), 8'h01);
    step();  // 53
    chk("resume_div", pend, 8'h80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
